// File: rtl/numbers_sched.sv
// Slot-value scheduler: round-robin write arbiter feeding four per-slot registers, and a
// band decoder that selects one register for the shared numbers renderer.
// Optional macro NUMBERS_FRAME_SYNC_EN: writes reach the display only at frame edges.
module numbers_sched #(
  parameter int Y_OFF  = 80,
  parameter int BAND_H = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_px,
  input  logic [9:0]  y_px,
  input  logic [3:0]  req,
  input  logic [63:0] wdata,
  output logic [3:0]  ack,
  output logic [15:0] var_out,
  output logic [1:0]  slot,
  output logic        slot_valid,
  output logic [3:0]  updated
);

  logic [15:0] r_pending [4];
  logic [15:0] r_active  [4];
  logic [1:0]  r_ptr;
  logic [3:0]  r_ack;
  logic [3:0]  r_updated;
  logic [15:0] r_var_out;
  logic [1:0]  r_slot;
  logic        r_slot_valid;

  logic [15:0] w_wslice [4];
  logic [3:0]  w_rot;
  logic [1:0]  w_off;
  logic        w_grant_valid;
  logic [1:0]  w_grant_idx;
  logic [3:0]  w_grant_oh;
  logic [3:0]  w_in_band;
  logic        w_slot_valid;
  logic [1:0]  w_slot_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      localparam logic [10:0] LO = 11'(Y_OFF + gi * BAND_H);
      localparam logic [10:0] HI = 11'(Y_OFF + (gi + 1) * BAND_H);
      assign w_wslice[gi]  = wdata[16*gi +: 16];
      assign w_in_band[gi] = ({1'b0, y_px} >= LO) && ({1'b0, y_px} < HI);
    end
  endgenerate

  // Rotate requests so bit 0 is the requester at the pointer; first set bit wins.
  assign w_rot = 4'({req, req} >> r_ptr);

  always_comb begin
    w_grant_valid = |w_rot;
    w_off         = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
  end

  assign w_grant_idx = r_ptr + w_off;
  assign w_grant_oh  = w_grant_valid ? (4'b0001 << w_grant_idx) : 4'b0000;

  always_comb begin
    w_slot_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_in_band[i]) w_slot_idx = 2'(i);
    end
  end
  assign w_slot_valid = |w_in_band;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= 2'd0;
      r_ack        <= 4'b0000;
      r_var_out    <= 16'h0000;
      r_slot       <= 2'd0;
      r_slot_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_pending[i] <= 16'h0000;
    end else begin
      r_ack <= w_grant_oh;
      if (w_grant_valid) begin
        r_pending[w_grant_idx] <= w_wslice[w_grant_idx];
        r_ptr                  <= w_grant_idx + 2'd1;
      end
      // Display path samples the active value as it stood before this edge.
      r_slot_valid <= w_slot_valid;
      r_slot       <= w_slot_valid ? w_slot_idx : 2'd0;
      r_var_out    <= w_slot_valid ? r_active[w_slot_idx] : 16'h0000;
    end
  end

`ifdef NUMBERS_FRAME_SYNC_EN
  logic [3:0] r_dirty;
  logic       r_fe_prev;
  logic       w_fe_cond;
  logic       w_frame_edge;
  logic       w_unused_x;

  assign w_fe_cond    = (x_px == 10'd0) && (y_px == 10'd0);
  assign w_frame_edge = w_fe_cond && !r_fe_prev;
  assign w_unused_x   = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dirty   <= 4'b0000;
      r_fe_prev <= 1'b0;
      r_updated <= 4'b0000;
      for (int i = 0; i < 4; i++) r_active[i] <= 16'h0000;
    end else begin
      r_fe_prev <= w_fe_cond;
      r_updated <= w_frame_edge ? r_dirty : 4'b0000;
      // A grant in the edge cycle survives the clear and waits for the next frame.
      r_dirty   <= (w_frame_edge ? 4'b0000 : r_dirty) | w_grant_oh;
      for (int i = 0; i < 4; i++) begin
        if (w_frame_edge && r_dirty[i]) r_active[i] <= r_pending[i];
      end
    end
  end
`else
  logic w_unused_x;
  assign w_unused_x = ^x_px;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_updated <= 4'b0000;
      for (int i = 0; i < 4; i++) r_active[i] <= 16'h0000;
    end else begin
      r_updated <= w_grant_oh;
      if (w_grant_valid) r_active[w_grant_idx] <= w_wslice[w_grant_idx];
    end
  end
`endif

  assign ack        = r_ack;
  assign updated    = r_updated;
  assign var_out    = r_var_out;
  assign slot       = r_slot;
  assign slot_valid = r_slot_valid;

endmodule

// File: tb/tb_numbers_sched.sv
// Bench for numbers_sched: directed scenarios plus randomized traffic, every cycle
// compared against a slot-level reference model.
module tb_numbers_sched;
  localparam int Y_OFF  = 80;
  localparam int BAND_H = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_px, y_px;
  logic [3:0]  req;
  logic [63:0] wdata;
  logic [3:0]  ack;
  logic [15:0] var_out;
  logic [1:0]  slot;
  logic        slot_valid;
  logic [3:0]  updated;

  always #5 clk = ~clk;

  numbers_sched #(.Y_OFF(Y_OFF), .BAND_H(BAND_H)) dut (
    .clk(clk), .reset(reset), .x_px(x_px), .y_px(y_px), .req(req), .wdata(wdata),
    .ack(ack), .var_out(var_out), .slot(slot), .slot_valid(slot_valid), .updated(updated)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: slot values and bookkeeping, plus outputs expected after each edge.
  logic [15:0] m_pend [4];
  logic [15:0] m_act  [4];
  logic [3:0]  m_dirty;
  int          m_ptr;
  bit          m_prev;
  logic [3:0]  e_ack, e_upd;
  logic [15:0] e_var;
  logic [1:0]  e_slot;
  logic        e_sv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int g;
    int k;
    int y;
    bit cond;
    bit fe;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_pend[i] = '0; m_act[i] = '0; end
      m_dirty = '0; m_ptr = 0; m_prev = 0;
      e_ack = '0; e_upd = '0; e_var = '0; e_slot = '0; e_sv = 0;
      return;
    end
    g = -1;
    for (int i = 0; i < 4; i++) begin
      k = (m_ptr + i) % 4;
      if (g < 0 && req[k]) g = k;
    end
    cond   = (x_px == 0) && (y_px == 0);
    fe     = cond && !m_prev;
    m_prev = cond;
    y = int'(y_px);
    if (y >= Y_OFF && y < Y_OFF + 4 * BAND_H) begin
      e_sv   = 1;
      e_slot = 2'((y - Y_OFF) / BAND_H);
      e_var  = m_act[e_slot];
    end else begin
      e_sv = 0; e_slot = '0; e_var = '0;
    end
    e_upd = '0;
`ifdef NUMBERS_FRAME_SYNC_EN
    if (fe) begin
      e_upd = m_dirty;
      for (int i = 0; i < 4; i++) if (m_dirty[i]) m_act[i] = m_pend[i];
      m_dirty = '0;
    end
`endif
    e_ack = '0;
    if (g >= 0) begin
      m_pend[g] = wdata[16*g +: 16];
      e_ack     = 4'b0001 << g;
      m_ptr     = (g + 1) % 4;
`ifdef NUMBERS_FRAME_SYNC_EN
      m_dirty[g] = 1'b1;
`else
      m_act[g] = m_pend[g];
      e_upd    = e_ack;
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", ack, e_ack);
    chk("updated", updated, e_upd);
    chk("var_out", var_out, e_var);
    chk("slot", slot, e_slot);
    chk("slot_valid", slot_valid, e_sv);
    chk("ack_onehot", ($countones(ack) <= 1), 1);
  endtask

  initial begin
    int sweep [6] = '{79, 80, 103, 104, 175, 176};
    reset = 1; x_px = '0; y_px = '0; req = '0; wdata = '0;
    step(); step();
    chk("reset_var", var_out, 16'h0000);
    reset = 0; x_px = 10'd5; y_px = 10'd5;

    // Single write to slot 0, then display in band 0 after a frame edge
    req = 4'b0001; wdata = 64'h0000_0000_0000_ABCD;
    step(); step();
    req = '0; step();
    x_px = 10'd0; y_px = 10'd0; step();
    x_px = 10'd5; y_px = 10'd80; step();
    chk("var_band0", var_out, 16'hABCD);
    step();

    // Continuous requests from all four, starting at pointer 0
    reset = 1; step(); reset = 0;
    req = 4'b1111; wdata = {$urandom, $urandom};
    repeat (6) step();
    req = '0;

    // Grant to requester 2 in the exact frame-edge cycle
    x_px = 10'd5; y_px = 10'd5; step();
    req = 4'b0100; wdata = 64'h0000_1234_0000_0000; x_px = 10'd0; y_px = 10'd0; step();
    req = '0; x_px = 10'd5; step(); step();
    x_px = 10'd0; y_px = 10'd0; step();
    x_px = 10'd5; y_px = 10'd128; step(); step();
    chk("var_band2", var_out, 16'h1234);

    // Band boundary sweep
    foreach (sweep[i]) begin
      y_px = 10'(sweep[i]); step();
    end

    // Reset in a grant cycle, then write slot 3
    req = 4'b1000; wdata = 64'h00FF_0000_0000_0000; reset = 1; step();
    reset = 0; req = '0; step();
    req = 4'b1000; step();
    req = '0; y_px = 10'd160; step(); step();
`ifndef NUMBERS_FRAME_SYNC_EN
    chk("var_band3_nosync", var_out, 16'h00FF);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(99) == 0);
      req   = 4'($urandom);
      wdata = {$urandom, $urandom};
      x_px  = ($urandom_range(3) == 0) ? 10'd0 : 10'($urandom_range(639));
      y_px  = ($urandom_range(3) == 0) ? 10'd0 : 10'($urandom_range(199));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/numbers_sched.md
NUMBERS_SCHED -- requirements
Module: numbers_sched

Interface
REQ-001 Parameter Y_OFF, default 80: first y_px line of slot 0 band.
REQ-002 Parameter BAND_H, default 24: height in lines of each slot band; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 x_px  input  10  current pixel column from the VGA timing block.
REQ-006 y_px  input  10  current pixel row from the VGA timing block.
REQ-007 req  input  4  per-requester write request, bit k = requester k.
REQ-008 wdata  input  64  write data; bits [16k+15:16k] belong to requester k.
REQ-009 ack  output  4  one-hot, one-cycle write acknowledge.
REQ-010 var_out  output  16  value for the shared numbers renderer's var0 input.
REQ-011 slot  output  2  index of the slot whose band contains y_px.
REQ-012 slot_valid  output  1  high when y_px is inside any slot band.
REQ-013 updated  output  4  one-cycle pulse per slot whose active value changed at a frame edge.

Function
REQ-014 Four 16-bit pending registers and four 16-bit active registers; var_out always sourced from an active register.
REQ-015 Arbiter: round-robin pointer ptr (2 bits); each cycle, grant the first k with req[k]=1, searching ptr, ptr+1, ... mod 4.
REQ-016 Grant: in the granted cycle, the pending[k] <= wdata slice k; ack[k]=1 in the following cycle; ptr <= k+1 mod 4; at most one grant per cycle.
REQ-017 Requester holds req and wdata stable until ack; a requester whose req stays high after ack is treated as a new request and re-arbitrated.
REQ-018 No request pending: no grant, ack=0, ptr unchanged.
REQ-019 Frame edge = first cycle where x_px==0 and y_px==0 after any cycle where that condition was false (registered previous-condition flag).
REQ-020 At frame edge, active[k] <= pending[k] for all k whose dirty[k]=1; then dirty cleared; updated[k]=1 on the next cycle for exactly those k.
REQ-021 Grant writing pending[k] sets dirty[k]; a grant in the same cycle as a frame edge lands in pending, is not copied this frame, and leaves dirty[k]=1.
REQ-022 Band decode: slot k active when Y_OFF+k*BAND_H <= y_px < Y_OFF+(k+1)*BAND_H, k=0..3, compares done at 11 bits (no wrap).
REQ-023 var_out, slot, slot_valid registered: reflect y_px sampled one cycle earlier (latency 1).
REQ-024 Outside all bands: slot_valid=0, slot=0, var_out=16'h0000.
REQ-025 A write may only reach var_out through a frame edge (tear-free display), unless REQ-030 applies.

Reset
REQ-026 reset clears pending, active, dirty, ptr, and the frame-edge flag to 0.
REQ-027 Outputs in the cycle after reset asserted: ack=0, var_out=0, slot=0, slot_valid=0, updated=0.
REQ-028 Reset mid-handshake: no ack is issued for a grant made in the reset cycle; the requester must re-request.
REQ-029 After reset release, the first cycle with x_px==0 and y_px==0 counts as a frame edge.

Configuration
REQ-030 Macro NUMBERS_FRAME_SYNC_EN: when defined, behaviour is as described in REQ-020/021/025.
REQ-031 When it is not defined: a grant writes pending[k] and active[k] in the same cycle; dirty is unused; updated[k] pulses with ack[k]; frame-edge logic is omitted.

Verification
REQ-032 Reset then req=4'b0001, wdata[15:0]=16'hABCD -> ack=4'b0001 one cycle later; var_out stays 0 until the frame edge; then at y_px=80 var_out=16'hABCD, slot=0, slot_valid=1.
REQ-033 req=4'b1111 held continuously, ptr=0 -> acks in order 0001,0010,0100,1000,0001; no cycle has two ack bits set.
REQ-034 Grant to requester 2 (16'h1234) in the exact frame-edge cycle -> updated[2]=0 that frame; active[2] becomes 16'h1234 at the next edge with updated[2]=1.
REQ-035 Band sweep with Y_OFF=80, BAND_H=24: y_px=79 -> slot_valid=0; 80 -> slot 0; 103 -> slot 0; 104 -> slot 1; 175 -> slot 3; 176 -> slot_valid=0; each output appears one cycle later.
REQ-036 Reset asserted in a grant cycle -> no ack, pending unchanged at 0; with NUMBERS_FRAME_SYNC_EN undefined, write 16'h00FF to slot 3 -> var_out=16'h00FF in band 3 with no frame edge.
